// File: rtl/prirv32_fetch_queue_pkg.sv
// Shared constants and the fetch-queue entry type for the priRV32 front end.
package prirv32_pkg;

  localparam int ILEN       = 32;  // instruction word width
  localparam int INST_BYTES = 4;   // bytes per instruction, sequential PC step
  localparam int PC_W       = 32;  // PC width carried in a queue entry

  // One buffered instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/prirv32_fetch_queue_if.sv
// Request/response/decode signal bundle between the fetch queue and its neighbours.
interface prirv32_fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  import prirv32_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  logic            imem_req_valid_o;
  logic            imem_req_ready_i;
  logic [XLEN-1:0] imem_req_addr_o;
  logic            imem_rsp_valid_i;
  logic [ILEN-1:0] imem_rsp_data_i;
  logic            redirect_i;
  logic [XLEN-1:0] redirect_addr_i;
  logic            inst_valid_o;
  logic            inst_ready_i;
  logic [ILEN-1:0] inst_data_o;
  logic [XLEN-1:0] inst_pc_o;
  logic [CW-1:0]   count_o;

  // The fetch queue itself.
  modport master (
    output imem_req_valid_o, imem_req_addr_o,
    output inst_valid_o, inst_data_o, inst_pc_o, count_o,
    input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
    input  redirect_i, redirect_addr_i, inst_ready_i
  );

  // Instruction memory, branch unit and decode seen together.
  modport slave (
    input  imem_req_valid_o, imem_req_addr_o,
    input  inst_valid_o, inst_data_o, inst_pc_o, count_o,
    output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
    output redirect_i, redirect_addr_i, inst_ready_i
  );

endinterface

// File: rtl/prirv32_fetch_queue_sync_fifo.sv
// Synchronous FIFO with flush; registered storage, head shown without bypass.
module prirv32_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output logic [WIDTH-1:0]             head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             full;
  logic             push_en;
  logic             pop_en;

  // Occupancy flags and guarded push/pop strobes.
  always_comb begin
    empty_o = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    push_en = push_i && !full;
    pop_en  = pop_i && !empty_o;
    count_o = CW'(wr_ptr - rd_ptr);
    head_o  = empty_o ? '0 : mem[rd_ptr[AW-1:0]];
  end

  // Pointer update; reset and flush both empty the queue.
  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write.
  always_ff @(posedge clk_i) begin
    // NOTE: storage is deliberately not reset; empty pointers make stale contents invisible.
    if (push_en) mem[wr_ptr[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/prirv32_fetch_queue.sv
// Instruction-fetch front end: credit-limited sequential fetch, in-order response
// capture into a queue, and redirect with discard of in-flight responses.
module prirv32_fetch_queue
  import prirv32_pkg::*;
#(
  parameter int              XLEN         = PC_W,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              DEPTH        = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  prirv32_fetch_queue_if.master bus
);

  localparam int              CW         = $clog2(DEPTH + 1);
  localparam logic [CW:0]     DEPTH_LIM  = (CW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] STEP       = XLEN'(INST_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INST_BYTES - 1);

  logic [XLEN-1:0] fetch_pc;     // next address to request
  logic [XLEN-1:0] rsp_pc;       // PC of the next kept response
  logic [CW-1:0]   outstanding;  // requests accepted but not yet answered
  logic [CW-1:0]   drop;         // responses still to be discarded after a redirect
  logic [CW-1:0]   fifo_count;
  logic [XLEN-1:0] redirect_pc;
  logic            req_valid;
  logic            req_accept;
  logic            rsp_drop;
  logic            push;
  logic            pop;
  logic            inst_valid;
  logic            fifo_empty;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;

  // Credit check, handshakes and queue strobes.
  always_comb begin
    // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
    req_valid   = !rst_i && !bus.redirect_i &&
                  (({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_LIM);
    req_accept  = req_valid && bus.imem_req_ready_i;
    rsp_drop    = (drop != '0);
    push        = bus.imem_rsp_valid_i && !rsp_drop && !bus.redirect_i;
    inst_valid  = !fifo_empty && !bus.redirect_i;
    pop         = inst_valid && bus.inst_ready_i;
    redirect_pc = bus.redirect_addr_i & ALIGN_MASK;
    push_entry.pc   = rsp_pc;
    push_entry.inst = bus.imem_rsp_data_i;

    bus.imem_req_valid_o = req_valid;
    bus.imem_req_addr_o  = fetch_pc;
    bus.inst_valid_o     = inst_valid;
    bus.inst_data_o      = head_entry.inst;
    bus.inst_pc_o        = head_entry.pc;
    bus.count_o          = fifo_count;
  end

  // PC tracking and in-flight bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc    <= RESET_VECTOR;
      rsp_pc      <= RESET_VECTOR;
      outstanding <= '0;
      drop        <= '0;
    end else if (bus.redirect_i) begin
      // Everything still in flight, minus the response discarded right now, is stale.
      fetch_pc    <= redirect_pc;
      rsp_pc      <= redirect_pc;
      outstanding <= outstanding - CW'(bus.imem_rsp_valid_i);
      drop        <= outstanding - CW'(bus.imem_rsp_valid_i);
    end else begin
      if (req_accept) fetch_pc <= fetch_pc + STEP;
      outstanding <= outstanding + CW'(req_accept) - CW'(bus.imem_rsp_valid_i);
      if (bus.imem_rsp_valid_i) begin
        if (rsp_drop) drop   <= drop - CW'(1);
        else          rsp_pc <= rsp_pc + STEP;
      end
    end
  end

  prirv32_sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .flush_i (bus.redirect_i),
    .head_o  (head_entry),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

endmodule
